// File: rtl/phase_sequencer_if.sv
// phase_sequencer_if: control/config inputs and phase/status outputs of the two-phase sequencer.
interface phase_sequencer_if #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
);
    logic               start;
    logic               stop;
    logic               cfg_we;
    logic [CNT_W-1:0]   cfg_high;
    logic [CNT_W-1:0]   cfg_gap;
    logic [BURST_W-1:0] burst_len;
    logic [1:0]         phase;
    logic               busy;
    logic               cycle_done;
    logic               cfg_err;
    modport master (
        output start, stop, cfg_we, cfg_high, cfg_gap, burst_len,
        input  phase, busy, cycle_done, cfg_err
    );
    modport slave (
        input  start, stop, cfg_we, cfg_high, cfg_gap, burst_len,
        output phase, busy, cycle_done, cfg_err
    );
endinterface

// File: rtl/phase_sequencer.sv
// phase_sequencer: two-phase non-overlapping clock sequencer with programmable high/gap time.
// Define PHASE_SEQ_BURST_EN to stop automatically after burst_len periods (0 = free-run).
module phase_sequencer #(
    parameter int CNT_W   = 8,
    parameter int BURST_W = 8
) (
    input  logic clk,
    input  logic rst,
    phase_sequencer_if.slave bus
);
    typedef enum logic [2:0] {IDLE, PH0, GAP0, PH1, GAP1} state_t;
    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, high_r, gap_r;
    logic             stop_pend, stop_pend_n;
    logic [1:0]       phase_r;
    logic             busy_r, cd_r, err_r, cd_n;
    logic             accept, last, period_end, finish, burst_done;

`ifdef PHASE_SEQ_BURST_EN
    logic [BURST_W-1:0] burst_r, per_cnt;
    assign burst_done = burst_r != '0 && per_cnt == burst_r - 1'b1;
    always_ff @(posedge clk) begin
        if (rst) begin
            burst_r <= '0;
            per_cnt <= '0;
        end else if (accept) begin
            burst_r <= bus.burst_len;
            per_cnt <= '0;
        end else if (period_end) begin
            per_cnt <= per_cnt + 1'b1;
        end
    end
`else
    logic unused_burst;
    assign unused_burst = ^bus.burst_len;
    assign burst_done   = 1'b0;
`endif

    always_comb begin
        accept      = state == IDLE && bus.start && !bus.stop;
        last        = (state == PH0 || state == PH1) ? cnt == high_r - 1'b1 :
                      (state == GAP0 || state == GAP1) ? cnt == gap_r - 1'b1 : 1'b0;
        period_end  = state == GAP1 && last;
        finish      = period_end && (stop_pend || bus.stop || burst_done);
        state_n     = state == IDLE ? (accept ? PH0 : IDLE) :
                      !last         ? state :
                      state == PH0  ? GAP0 :
                      state == GAP0 ? PH1 :
                      state == PH1  ? GAP1 :
                      finish        ? IDLE : PH0;
        // every non-idle state change coincides with `last`, so the counter restarts there
        cnt_n       = (state == IDLE || last) ? '0 : cnt + 1'b1;
        stop_pend_n = state_n == IDLE ? 1'b0 : stop_pend | bus.stop;
        cd_n        = state_n == GAP1 && cnt_n == gap_r - 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            cnt       <= '0;
            high_r    <= CNT_W'(1);
            gap_r     <= CNT_W'(1);
            stop_pend <= 1'b0;
            phase_r   <= 2'b00;
            busy_r    <= 1'b0;
            cd_r      <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            stop_pend <= stop_pend_n;
            if (bus.cfg_we && state == IDLE) begin
                high_r <= bus.cfg_high == '0 ? CNT_W'(1) : bus.cfg_high;
                gap_r  <= bus.cfg_gap == '0 ? CNT_W'(1) : bus.cfg_gap;
            end
            phase_r   <= {state_n == PH1, state_n == PH0};
            busy_r    <= state_n != IDLE;
            cd_r      <= cd_n;
            err_r     <= bus.cfg_we && state != IDLE;
        end
    end

    assign bus.phase      = phase_r;
    assign bus.busy       = busy_r;
    assign bus.cycle_done = cd_r;
    assign bus.cfg_err    = err_r;

    a_no_overlap: assert property (@(posedge clk) phase_r != 2'b11);
endmodule

// File: tb/tb_phase_sequencer.sv
// tb_phase_sequencer: directed scoreboard bench; expected per-cycle {phase,busy,cycle_done,cfg_err} is queued by stimulus.
module tb_phase_sequencer;
    logic clk = 1'b0;
    logic rst;
    int   errors = 0;
    int   checks = 0;
    logic [4:0] exp_q[$];
    string      tag_q[$];

    phase_sequencer_if #(.CNT_W(8), .BURST_W(8)) bus ();
    phase_sequencer #(.CNT_W(8), .BURST_W(8)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    localparam logic [4:0] IDL = 5'b00000;
    localparam logic [4:0] P0  = 5'b01100;
    localparam logic [4:0] P1  = 5'b10100;
    localparam logic [4:0] GP  = 5'b00100;
    localparam logic [4:0] CD  = 5'b00110;

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            logic [4:0] e, a;
            string t;
            e = exp_q.pop_front();
            t = tag_q.pop_front();
            a = {bus.phase, bus.busy, bus.cycle_done, bus.cfg_err};
            checks++;
            if (a !== e) begin
                errors++;
                $display("FAIL %s: got {phase,busy,cd,err}=%b expected %b at %0t", t, a, e, $time);
            end
        end
    end

    task automatic push(input logic [4:0] v, input string t);
        exp_q.push_back(v);
        tag_q.push_back(t);
    endtask

    task automatic push_n(input logic [4:0] v, input int n, input string t);
        for (int i = 0; i < n; i++) push(v, t);
    endtask

    task automatic push_period(input int h, input int g, input string t);
        push_n(P0, h, t);
        push_n(GP, g, t);
        push_n(P1, h, t);
        push_n(GP, g - 1, t);
        push(CD, t);
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() > 0 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expected entries left, required 0", exp_q.size());
            exp_q.delete();
            tag_q.delete();
        end
        tick();
    endtask

    initial begin
        int base;
        rst = 1'b1;
        bus.start = 1'b0; bus.stop = 1'b0; bus.cfg_we = 1'b0;
        bus.cfg_high = '0; bus.cfg_gap = '0; bus.burst_len = '0;
        tick(2);
        push(IDL, "reset");
        rst = 1'b0;
        drain();

        // default 1/1 timing, start ignored while busy, stop ends after 3rd period
        bus.start = 1'b1;
        push(IDL, "t1_idle");
        repeat (3) push_period(1, 1, "t1_period");
        push_n(IDL, 2, "t1_stopped");
        tick(); bus.start = 1'b0;
        tick(3); bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(4); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        drain();

        // high=3 gap=2, stop in 2nd cycle of PH0 of period 2
        bus.cfg_we = 1'b1; bus.cfg_high = 8'd3; bus.cfg_gap = 8'd2;
        push_n(IDL, 2, "t2_idle");
        repeat (2) push_period(3, 2, "t2_period");
        push_n(IDL, 2, "t3_stopped");
        tick(); bus.cfg_we = 1'b0; bus.start = 1'b1;
        tick(); bus.start = 1'b0;
        tick(11); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        drain();

        // cfg_we while busy flags cfg_err and leaves 3/2 timing intact
        bus.start = 1'b1;
        base = exp_q.size();
        push(IDL, "t4_idle");
        push_period(3, 2, "t4_period");
        push_n(IDL, 2, "t4_stopped");
        exp_q[base + 2][0] = 1'b1;
        tick(); bus.start = 1'b0; bus.stop = 1'b1;
        bus.cfg_we = 1'b1; bus.cfg_high = 8'd7; bus.cfg_gap = 8'd7;
        tick(); bus.stop = 1'b0; bus.cfg_we = 1'b0;
        drain();

        // start and stop together in IDLE: stays idle
        bus.start = 1'b1; bus.stop = 1'b1;
        push_n(IDL, 3, "t4_start_stop");
        tick(); bus.start = 1'b0; bus.stop = 1'b0;
        drain();

        // reset in first PH1 cycle drops everything, config back to 1/1
        bus.start = 1'b1;
        push(IDL, "t5_idle");
        push_n(P0, 3, "t5_ph0");
        push_n(GP, 2, "t5_gap0");
        push(P1, "t5_ph1");
        push_n(IDL, 2, "t5_reset");
        tick(); bus.start = 1'b0;
        tick(5); rst = 1'b1;
        tick(); rst = 1'b0;
        drain();
        bus.start = 1'b1;
        push(IDL, "t5_idle2");
        push_period(1, 1, "t5_default_cfg");
        push_n(IDL, 2, "t5_stopped");
        tick(); bus.start = 1'b0; bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        drain();

        // zero config clamps to 1
        bus.cfg_we = 1'b1; bus.cfg_high = 8'd0; bus.cfg_gap = 8'd0;
        push_n(IDL, 2, "clamp_idle");
        push_period(1, 1, "clamp_period");
        push(IDL, "clamp_stopped");
        tick(); bus.cfg_we = 1'b0; bus.start = 1'b1;
        tick(); bus.start = 1'b0; bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        drain();

`ifdef PHASE_SEQ_BURST_EN
        bus.burst_len = 8'd3; bus.start = 1'b1;
        push(IDL, "t6_idle");
        repeat (3) push_period(1, 1, "t6_burst");
        push_n(IDL, 2, "t6_done");
        tick(); bus.start = 1'b0;
        drain();
        bus.burst_len = 8'd0; bus.start = 1'b1;
        push(IDL, "t6_idle2");
        repeat (2) push_period(1, 1, "t6_freerun");
        push(IDL, "t6_stopped");
        tick(); bus.start = 1'b0;
        tick(4); bus.stop = 1'b1;
        tick(); bus.stop = 1'b0;
        drain();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, required completion");
        $fatal(1);
    end
endmodule
